// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 3x3 Sobel filter.
// Mode encodings, frame state and the saturating absolute value.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_GX   = 2'd0,
    MODE_GY   = 2'd1,
    MODE_MAG  = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } frame_st_e;

  localparam int unsigned GUARD_W = 4;

  function automatic logic [31:0] sat_abs(
    input logic signed [31:0] v,
    input int unsigned        w
  );
    logic [31:0] a;
    logic [31:0] lim;
    a   = (v < 0) ? 32'(-v) : 32'(v);
    lim = (32'd1 << w) - 32'd1;
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage: write at the current column, read
// the next column ahead so its data is ready when that pixel arrives.
module conv_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/conv3x3_stream_filter.sv
// Raster-stream 3x3 Sobel filter: frame FSM, two line buffers,
// window registers and a 3-stage arithmetic pipeline.
module conv3x3_stream_filter
  import conv_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [PIX_W-1:0] out_pix
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = PIX_W + GUARD_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  frame_st_e st_q, st_d;
  mode_e     mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic accept;
  logic last_px;

  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] lb2_rd;

  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic  s1_valid_q, s1_valid_d;
  logic  s1_sof_q, s1_sof_d;
  logic  s1_eof_q, s1_eof_d;
  mode_e s1_mode_q, s1_mode_d;

  logic signed [SW-1:0] s2_gx_q, s2_gx_d;
  logic signed [SW-1:0] s2_gy_q, s2_gy_d;
  logic [PIX_W-1:0] s2_ctr_q, s2_ctr_d;
  logic  s2_valid_q, s2_valid_d;
  logic  s2_sof_q, s2_sof_d;
  logic  s2_eof_q, s2_eof_d;
  mode_e s2_mode_q, s2_mode_d;

  logic signed [31:0] gx32;
  logic signed [31:0] gy32;
  logic [31:0] ax;
  logic [31:0] ay;
  logic [PIX_W-1:0] res;

  logic out_valid_q, out_valid_d;
  logic out_sof_q, out_sof_d;
  logic out_eof_q, out_eof_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;

  function automatic logic signed [SW-1:0] sx(
    input logic [PIX_W-1:0] p
  );
    return $signed({{GUARD_W{1'b0}}, p});
  endfunction

  always_comb begin
    accept  = in_valid && (in_sof || st_q == ST_ACTIVE);
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    last_px = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    st_d    = st_q;
    mode_d  = mode_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (in_sof) begin
        mode_d = mode_e'(mode);
      end
      if (last_px) begin
        st_d  = ST_DONE;
        col_d = '0;
        row_d = '0;
      end else begin
        st_d = ST_ACTIVE;
        if (cur_col == COL_LAST) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
          row_d = cur_row;
        end
      end
    end
  end

  // lb1 holds row-1; lb2 is fed from lb1 so it holds row-2
  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (cur_col),
    .wr_data (in_pix),
    .rd_en   (accept),
    .rd_addr (col_d),
    .rd_data (lb1_rd)
  );

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb2 (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (cur_col),
    .wr_data (lb1_rd),
    .rd_en   (accept),
    .rd_addr (col_d),
    .rd_data (lb2_rd)
  );

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pix;
    end
    s1_valid_d = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    s1_sof_d   = accept && (cur_row == RW'(2)) && (cur_col == CW'(2));
    s1_eof_d   = accept && last_px;
    s1_mode_d  = mode_d;
  end

  always_comb begin
    s2_gx_d = (sx(win_q[2]) + (sx(win_q[5]) <<< 1) + sx(win_q[8]))
            - (sx(win_q[0]) + (sx(win_q[3]) <<< 1) + sx(win_q[6]));
    s2_gy_d = (sx(win_q[6]) + (sx(win_q[7]) <<< 1) + sx(win_q[8]))
            - (sx(win_q[0]) + (sx(win_q[1]) <<< 1) + sx(win_q[2]));
    s2_ctr_d   = win_q[4];
    s2_valid_d = s1_valid_q;
    s2_sof_d   = s1_sof_q;
    s2_eof_d   = s1_eof_q;
    s2_mode_d  = s1_mode_q;
  end

  always_comb begin
    gx32 = 32'(s2_gx_q);
    gy32 = 32'(s2_gy_q);
    ax   = sat_abs(gx32, 31);
    ay   = sat_abs(gy32, 31);
    res  = '0;
    unique case (s2_mode_q)
      MODE_GX:   res = PIX_W'(sat_abs(gx32, PIX_W));
      MODE_GY:   res = PIX_W'(sat_abs(gy32, PIX_W));
      MODE_MAG:  res = PIX_W'(sat_abs(signed'(ax + ay), PIX_W));
      MODE_PASS: res = s2_ctr_q;
    endcase
    out_valid_d = s2_valid_q;
    out_sof_d   = s2_valid_q && s2_sof_q;
    out_eof_d   = s2_valid_q && s2_eof_q;
    out_pix_d   = s2_valid_q ? res : out_pix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      mode_q      <= MODE_GX;
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eof_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      st_q        <= st_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_eof_q    <= s2_eof_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // datapath registers are qualified by the valids above
  always_ff @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      win_q[k] <= win_d[k];
    end
    s1_mode_q <= s1_mode_d;
    s2_gx_q   <= s2_gx_d;
    s2_gy_q   <= s2_gy_d;
    s2_ctr_q  <= s2_ctr_d;
    s2_mode_q <= s2_mode_d;
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Bench for conv3x3_stream_filter: three image geometries driven
// from one sequence, results checked against a queued reference.
module tb_conv3x3_stream_filter;

  typedef struct {
    int pix;
    bit sof;
    bit eof;
    int at;
  } exp_t;

  exp_t q[3][$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode;
  logic [2:0]  iv;
  logic        in_sof;
  logic [11:0] in_pix;
  logic [2:0]  ov;
  logic [2:0]  osof;
  logic [2:0]  oeof;
  logic [11:0] opix [3];

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int img [6][8];
  int last_pix [3];

  conv3x3_stream_filter #(.PIX_W(12), .IMG_W(3), .IMG_H(3)) u3 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[0]),
    .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov[0]),
    .out_sof(osof[0]), .out_eof(oeof[0]), .out_pix(opix[0])
  );

  conv3x3_stream_filter #(.PIX_W(12), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[1]),
    .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov[1]),
    .out_sof(osof[1]), .out_eof(oeof[1]), .out_pix(opix[1])
  );

  conv3x3_stream_filter #(.PIX_W(12), .IMG_W(8), .IMG_H(6)) u8 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[2]),
    .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov[2]),
    .out_sof(osof[2]), .out_eof(oeof[2]), .out_pix(opix[2])
  );

  always @(posedge clk) edges <= edges + 1;

  function automatic int model(int md, int r, int c);
    int x [9];
    int gx, gy, ax, ay, v;
    for (int k = 0; k < 9; k++) x[k] = img[r-2+k/3][c-2+k%3];
    gx = (x[2] + 2*x[5] + x[8]) - (x[0] + 2*x[3] + x[6]);
    gy = (x[6] + 2*x[7] + x[8]) - (x[0] + 2*x[1] + x[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      0:       v = ax;
      1:       v = ay;
      2:       v = ax + ay;
      default: v = x[4];
    endcase
    return (v > 4095) ? 4095 : v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        last_pix[i] = 0;
      end else if (ov[i]) begin
        checks++;
        assert (q[i].size() > 0) else begin
          errors++;
          $error("FAIL extra_out%0d got=%0d want=none", i, opix[i]);
        end
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          checks++;
          assert (opix[i] === 12'(e.pix)) else begin
            errors++;
            $error("FAIL pix%0d got=%0d want=%0d", i, opix[i], e.pix);
          end
          checks++;
          assert (osof[i] === e.sof) else begin
            errors++;
            $error("FAIL sof%0d got=%b want=%b", i, osof[i], e.sof);
          end
          checks++;
          assert (oeof[i] === e.eof) else begin
            errors++;
            $error("FAIL eof%0d got=%b want=%b", i, oeof[i], e.eof);
          end
          checks++;
          assert (edges === e.at) else begin
            errors++;
            $error("FAIL lat%0d got=%0d want=%0d", i, edges, e.at);
          end
          last_pix[i] = e.pix;
        end
      end else begin
        checks++;
        assert (opix[i] === 12'(last_pix[i])) else begin
          errors++;
          $error("FAIL hold%0d got=%0d want=%0d", i, opix[i], last_pix[i]);
        end
        checks++;
        assert ({osof[i], oeof[i]} === 2'b00) else begin
          errors++;
          $error("FAIL flags%0d got=%b%b want=00", i, osof[i], oeof[i]);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      iv = '0;
      in_sof = 1'b0;
    end
  endtask

  task automatic send(int s, int r, int c, bit sof, bit push,
                      int md, int mv, int w, int h);
    @(negedge clk);
    iv = '0;
    iv[s] = 1'b1;
    in_sof = sof;
    in_pix = 12'(img[r][c]);
    mode = 2'(mv);
    if (push && r >= 2 && c >= 2)
      q[s].push_back('{pix: model(md, r, c),
                       sof: (r == 2 && c == 2),
                       eof: (r == h-1 && c == w-1),
                       at:  edges + 3});
  endtask

  task automatic frame(int s, int w, int h, int md, int md_after,
                       int gap_max, int npix);
    int n;
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < npix) begin
          if (gap_max > 0) idle($urandom_range(0, gap_max));
          send(s, r, c, (r == 0 && c == 0), 1'b1, md,
               (n == 0) ? md : md_after, w, h);
          n++;
        end
      end
    end
  endtask

  task automatic chk_zero(int i);
    checks++;
    assert (ov[i] === 1'b0) else begin
      errors++; $error("FAIL rst_valid%0d got=%b want=0", i, ov[i]);
    end
    checks++;
    assert (osof[i] === 1'b0) else begin
      errors++; $error("FAIL rst_sof%0d got=%b want=0", i, osof[i]);
    end
    checks++;
    assert (oeof[i] === 1'b0) else begin
      errors++; $error("FAIL rst_eof%0d got=%b want=0", i, oeof[i]);
    end
    checks++;
    assert (opix[i] === 12'd0) else begin
      errors++; $error("FAIL rst_pix%0d got=%0d want=0", i, opix[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    iv = '0;
    in_sof = 1'b0;
    in_pix = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) img[k/3][k%3] = k + 1;
    for (int k = 0; k < 5; k++) send(0, k/3, k%3, 1'b0, 1'b0, 0, 0, 3, 3);
    idle(6);
    for (int md = 0; md < 4; md++) begin
      frame(0, 3, 3, md, md, 0, 9);
      idle(2);
    end
    idle(4);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = (c == 0) ? 0 : 4095;
    frame(1, 4, 4, 2, 2, 0, 16);
    idle(6);

    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) img[r][c] = ((r * 8 + c) * 61) % 4096;
    frame(2, 8, 6, 2, 2, 0, 48);
    idle(4);
    frame(2, 8, 6, 2, 2, 5, 48);
    idle(4);
    frame(2, 8, 6, 0, 0, 3, 48);
    idle(4);

    frame(2, 8, 6, 1, 0, 0, 48);
    idle(2);
    for (int k = 0; k < 10; k++) send(2, k/8, k%8, 1'b0, 1'b0, 0, 2, 8, 6);
    idle(6);
    frame(2, 8, 6, 3, 3, 0, 12);
    frame(2, 8, 6, 3, 3, 0, 48);
    idle(6);

    frame(2, 8, 6, 2, 2, 0, 20);
    @(negedge clk);
    rst = 1'b1;
    iv = '0;
    in_sof = 1'b0;
    q[2].delete();
    @(negedge clk);
    chk_zero(2);
    rst = 1'b0;
    idle(5);
    frame(2, 8, 6, 2, 2, 0, 48);
    idle(6);

    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (q[i].size() == 0) else begin
        errors++;
        $error("FAIL missing%0d got=%0d want=0", i, q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
